// File: rtl/toggle_stim_gen_pkg.sv
// Shared types and constants for the toggle stimulus generator.
// Used by the top-level FSM and by the LFSR sub-module.
package toggle_stim_gen_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'd0,
        MODE_ALT  = 2'd1,
        MODE_PRBS = 2'd2,
        MODE_WALK = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [15:0] LFSR_MASK  = 16'hB400;
    localparam logic [23:0] TOGGLE_SAT = 24'hFFFFFF;
    localparam logic [3:0]  ACT_ALWAYS = 4'hF;

    // Galois form: shift right, fold the mask in when the bit shifted out is 1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

endpackage

// File: rtl/toggle_stim_gen_lfsr.sv
// 16-bit Galois LFSR with a seed load and an advance enable.
// A seed load takes priority over an advance.
module stim_lfsr16
    import toggle_stim_gen_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        CLK,
    input  logic        RSTB,
    input  logic        load_i,
    input  logic        adv_i,
    output logic [15:0] state_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = SEED;
        end else if (adv_i) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/toggle_stim_gen.sv
// Toggle stimulus generator: drives a pattern vector for a fixed number of
// cycles and counts the bit flips it produced.
//
// state   | meaning
// IDLE    | waiting for start; d_out and toggle_cnt hold last run's values
// RUN     | live stimulus, valid=1, one LFSR step and counter decrement per cycle
// DONE    | one-cycle completion pulse, d_out held, then back to IDLE
module toggle_stim_gen
    import toggle_stim_gen_pkg::*;
#(
    parameter int          WIDTH = 8,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [1:0]       mode_i,
    input  logic [3:0]       activity_i,
    input  logic [15:0]      num_cycles_i,
    output logic [WIDTH-1:0] d_out_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [23:0]      toggle_cnt_o
);

    localparam logic [WIDTH-1:0] WALK_FIRST = WIDTH'(1);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [3:0]        act_q, act_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic [23:0]       tcnt_q, tcnt_d;

    logic              lfsr_load;
    logic              lfsr_adv;
    logic [15:0]       lfsr;
    logic              unused_lfsr_hi;

    logic              upd;
    logic [WIDTH-1:0]  dout_nxt;
    logic [WIDTH-1:0]  flips;
    logic [4:0]        pop;
    logic [24:0]       tc_sum;
    logic [23:0]       tcnt_sat;

    stim_lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .CLK     (CLK),
        .RSTB    (RSTB),
        .load_i  (lfsr_load),
        .adv_i   (lfsr_adv),
        .state_o (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr;

    assign upd = (act_q == ACT_ALWAYS) || (lfsr[3:0] < act_q);

    always_comb begin
        dout_nxt = dout_q;
        case (mode_q)
            MODE_HOLD: dout_nxt = dout_q;
            MODE_ALT:  dout_nxt = ~dout_q;
            MODE_PRBS: dout_nxt = lfsr[WIDTH-1:0];
            MODE_WALK: dout_nxt = (dout_q == '0) ? WALK_FIRST
                                 : ((dout_q << 1) | (dout_q >> (WIDTH-1)));
            default:   dout_nxt = dout_q;
        endcase
    end

    assign flips = dout_q ^ dout_nxt;

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + 5'(flips[i]);
        end
    end

    assign tc_sum   = {1'b0, tcnt_q} + {20'd0, pop};
    assign tcnt_sat = tc_sum[24] ? TOGGLE_SAT : tc_sum[23:0];

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        act_d     = act_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        tcnt_d    = tcnt_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    mode_d    = mode_e'(mode_i);
                    act_d     = activity_i;
                    cnt_d     = num_cycles_i;
                    dout_d    = '0;
                    tcnt_d    = '0;
                    lfsr_load = 1'b1;
                    state_d   = (num_cycles_i == 16'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                lfsr_adv = 1'b1;
                if (abort_i) begin
                    state_d = ST_IDLE;
                    dout_d  = '0;
                    cnt_d   = '0;
                end else begin
                    if (upd) begin
                        dout_d = dout_nxt;
                        tcnt_d = tcnt_sat;
                    end
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (abort_i) begin
                    dout_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_HOLD;
            act_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            act_q   <= act_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign d_out_o      = dout_q;
    assign valid_o      = (state_q == ST_RUN);
    assign busy_o       = (state_q != ST_IDLE);
    // An abort arriving in DONE suppresses the completion pulse.
    assign done_o       = (state_q == ST_DONE) && !abort_i;
    assign toggle_cnt_o = tcnt_q;

endmodule
